alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter CNT_W, default 16: width of the completed-operation counter.
REQ-002 clk  in  1  rising-edge clock, single clock domain.
REQ-003 rst_n  in  1  reset, asynchronous and active-low.
REQ-004 req0_valid  in  1  requester 0 (execute stage) has an operation pending.
REQ-005 req0_ready  out  1  requester 0 operation accepted this cycle.
REQ-006 req0_a, req0_b  in  32 each  requester 0 operands.
REQ-007 req0_op  in  3  requester 0 ALU op code: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 SRL, 111 SLT signed.
REQ-008 req1_valid, req1_ready, req1_a, req1_b, req1_op: same widths and meanings for requester 1 (address/branch-target unit).
REQ-009 rsp_valid  out  1  response slot holds a result.
REQ-010 rsp_ready  in  1  consumer accepts the response.
REQ-011 rsp_id  out  1  requester that owns the response.
REQ-012 rsp_result  out  32  ALU result.
REQ-013 rsp_zero  out  1  rsp_result == 0.
REQ-014 op_count  out  CNT_W  number of responses consumed, wraps modulo 2^CNT_W.

Function
REQ-015 The block SHALL instantiate exactly one ALU and share it between the two requesters; op encodings and shift amounts (b[4:0]) SHALL match the core ALU.
REQ-016 A response-slot FSM SHALL have two states, EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-017 can_accept = EMPTY, or FULL with rsp_ready=1 (drain and refill in the same cycle).
REQ-018 An accept occurs when can_accept=1 and at least one reqN_valid=1; only the granted requester's reqN_ready SHALL be 1, and the other requester's ready SHALL be 0.
REQ-019 reqN_ready SHALL be combinational from the valids and the slot state; a requester SHALL NOT make valid depend on ready.
REQ-020 Arbitration SHALL be round-robin: with one requester valid, grant it; with both valid, grant the requester not granted at the last accept.
REQ-021 The last-grant pointer SHALL update only on an accept.
REQ-022 On accept, the slot SHALL capture the ALU result, the zero flag and the id at the next clock edge: latency 1 cycle, throughput 1 op per cycle while rsp_ready=1.
REQ-023 Transitions SHALL be: EMPTY->FULL on accept; FULL->EMPTY on rsp_ready with no accept; FULL->FULL on rsp_ready with accept (new data loaded), or on rsp_ready=0 (data held).
REQ-024 While FULL and rsp_ready=0, rsp_id, rsp_result and rsp_zero SHALL be stable, and both readys SHALL be 0.
REQ-025 op_count SHALL increment by 1 on each cycle with rsp_valid and rsp_ready both 1, and SHALL wrap from all-ones to 0.
REQ-026 Operands that are not granted SHALL NOT affect any output.

Reset
REQ-027 While rst_n=0, asynchronously: rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, op_count=0, last-grant pointer=1 (requester 0 wins the first contention).
REQ-028 Reset asserted mid-operation SHALL discard the held response without a handshake.
REQ-029 req0_ready and req1_ready SHALL be 0 while rst_n=0.

Configuration
REQ-030 Macro ALU_ARB_FIXED_PRIO_EN defined: requester 0 SHALL always win when both requesters are valid, and the pointer SHALL be unused.
REQ-031 Macro ALU_ARB_FIXED_PRIO_EN undefined (default): the round-robin arbitration of REQ-020 and REQ-021 SHALL apply.

Verification
REQ-032 Single request: req0 a=5, b=3, op=000, rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=0, rsp_result=8, rsp_zero=0; op_count=1 after consumption.
REQ-033 Contention after reset: both valid for 4 cycles, rsp_ready=1 -> accept order 0,1,0,1 with one response per cycle; with ALU_ARB_FIXED_PRIO_EN the order SHALL be 0,0,0,0.
REQ-034 Backpressure: req1 a=0xFFFFFFFF, b=1, op=111 accepted, then rsp_ready=0 for 3 cycles -> rsp_result=1 and rsp_id=1 held stable, both readys 0; raising rsp_ready drains the slot and the same-cycle accept refills it.
REQ-035 Zero and shift: req0 a=7, b=7, op=001 -> rsp_result=0, rsp_zero=1; req0 a=1, b=0x21, op=101 -> rsp_result=2.
REQ-036 Reset mid-operation: rst_n pulsed low while FULL -> rsp_valid=0 immediately, op_count=0; the first contention after reset grants requester 0.
REQ-037 Wrap: CNT_W=4, 17 consumed responses -> op_count=1.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: one shared 32-bit ALU serving two requesters (execute stage
// and address/branch-target unit) through a single-entry response slot.
// Requests are granted round-robin by default; defining the macro
// ALU_ARB_FIXED_PRIO_EN switches to fixed priority with requester 0 winning.
// A completed-operation counter of CNT_W bits counts consumed responses.
module alu_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [2:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [2:0]       req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [31:0]      rsp_result,
  output logic             rsp_zero,
  output logic [CNT_W-1:0] op_count
);

  // ALU op codes, shared with the core ALU
  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SLL = 3'b101,
    OP_SRL = 3'b110,
    OP_SLT = 3'b111
  } alu_op_e;

  // Response slot: EMPTY means rsp_valid=0, FULL means a result is waiting
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  slot_state_e state;

  logic        any_valid;
  logic        can_accept;
  logic        accept;
  logic        grant_id;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  alu_op_e     alu_op;
  logic [31:0] alu_y;
  logic        alu_zero;

  assign any_valid = req0_valid | req1_valid;

  // The slot can take a new result when empty, or when full and being drained
  // this very cycle. Held low in reset so no request is acknowledged then.
  assign can_accept = rst_n & ((state == EMPTY) | rsp_ready);
  assign accept     = can_accept & any_valid;

  assign req0_ready = accept & ~grant_id;
  assign req1_ready = accept &  grant_id;

`ifdef ALU_ARB_FIXED_PRIO_EN

  // Fixed priority: requester 1 is chosen only when requester 0 is idle
  always_comb begin
    grant_id = ~req0_valid;
  end

`else

  // Identity of the requester granted at the most recent accept; resets to 1
  // so requester 0 wins the first contention.
  logic last_grant;

  // Round-robin choice: a lone requester wins, otherwise alternate
  always_comb begin
    if (req0_valid && req1_valid) begin
      grant_id = ~last_grant;
    end else begin
      grant_id = ~req0_valid;
    end
  end

  // Remember who was served, but only when something was actually accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= grant_id;
    end
  end

`endif

  // Operand steering: only the granted requester's operands reach the ALU
  always_comb begin
    if (grant_id) begin
      alu_a  = req1_a;
      alu_b  = req1_b;
      alu_op = alu_op_e'(req1_op);
    end else begin
      alu_a  = req0_a;
      alu_b  = req0_b;
      alu_op = alu_op_e'(req0_op);
    end
  end

  // The single shared ALU; shifts use the low five bits of b
  always_comb begin
    alu_y = 32'd0;
    case (alu_op)
      OP_ADD: alu_y = alu_a + alu_b;
      OP_SUB: alu_y = alu_a - alu_b;
      OP_AND: alu_y = alu_a & alu_b;
      OP_OR:  alu_y = alu_a | alu_b;
      OP_XOR: alu_y = alu_a ^ alu_b;
      OP_SLL: alu_y = alu_a << alu_b[4:0];
      OP_SRL: alu_y = alu_a >> alu_b[4:0];
      OP_SLT: alu_y = {31'd0, ($signed(alu_a) < $signed(alu_b))};
      default: alu_y = 32'd0;
    endcase
  end

  assign alu_zero = (alu_y == 32'd0);

  assign rsp_valid = (state == FULL);

  // Slot FSM: loads result/zero/id on accept, holds while stalled, counts drains
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      rsp_id     <= 1'b0;
      rsp_result <= 32'd0;
      rsp_zero   <= 1'b0;
      op_count   <= '0;
    end else begin
      if ((state == FULL) && rsp_ready) begin
        op_count <= op_count + CNT_ONE;
      end
      if (accept) begin
        rsp_id     <= grant_id;
        rsp_result <= alu_y;
        rsp_zero   <= alu_zero;
      end
      case (state)
        EMPTY: begin
          if (accept) begin
            state <= FULL;
          end
        end
        FULL: begin
          if (rsp_ready && !accept) begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed, table-driven bench for alu_arbiter (CNT_W=4),
// plus hand-written sequences for reset-in-flight, post-reset contention
// and counter wrap. Expectations follow ALU_ARB_FIXED_PRIO_EN if defined.
module tb_alu_arbiter;

`ifdef ALU_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_op, req1_op;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_zero;
  logic [31:0] rsp_result;
  logic [3:0]  op_count;

  int n_vectors;
  int n_miscompares;

  alu_arbiter #(.CNT_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .op_count   (op_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        v0;
    logic [31:0] a0;
    logic [31:0] b0;
    logic [2:0]  op0;
    logic        v1;
    logic [31:0] a1;
    logic [31:0] b1;
    logic [2:0]  op1;
    logic        rdy;
    logic        e_r0;
    logic        e_r1;
    logic        e_valid;
    logic        e_id;
    logic [31:0] e_result;
    logic        e_zero;
    logic [3:0]  e_count;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                              input logic [2:0] op0, input logic v1, input logic [31:0] a1,
                              input logic [31:0] b1, input logic [2:0] op1, input logic rdy,
                              input logic e_r0, input logic e_r1, input logic e_valid,
                              input logic e_id, input logic [31:0] e_result, input logic e_zero,
                              input logic [3:0] e_count);
    vec_t v;
    v.v0 = v0; v.a0 = a0; v.b0 = b0; v.op0 = op0;
    v.v1 = v1; v.a1 = a1; v.b1 = b1; v.op1 = op1;
    v.rdy = rdy;
    v.e_r0 = e_r0; v.e_r1 = e_r1; v.e_valid = e_valid; v.e_id = e_id;
    v.e_result = e_result; v.e_zero = e_zero; v.e_count = e_count;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_vectors++;
    if (actual !== expected) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Drive one vector's inputs on the falling edge, away from the sampling edge
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    req0_valid = v.v0; req0_a = v.a0; req0_b = v.b0; req0_op = v.op0;
    req1_valid = v.v1; req1_a = v.a1; req1_b = v.b1; req1_op = v.op1;
    rsp_ready  = v.rdy;
  endtask

  initial begin
    n_vectors     = 0;
    n_miscompares = 0;

    // Vectors: inputs, pre-edge readys, post-edge slot contents and count
    vecs[0]  = mk(1, 32'd5, 32'd3, 3'b000, 0, 32'd0, 32'd0, 3'b000, 1,
                  1, 0, 1, 0, 32'd8, 0, 4'd0);
    vecs[1]  = mk(0, 32'd0, 32'd0, 3'b000, 0, 32'd0, 32'd0, 3'b000, 1,
                  0, 0, 0, 0, 32'd0, 0, 4'd1);
    vecs[2]  = mk(1, 32'd7, 32'd7, 3'b001, 0, 32'd0, 32'd0, 3'b000, 1,
                  1, 0, 1, 0, 32'd0, 1, 4'd1);
    vecs[3]  = mk(1, 32'd1, 32'h21, 3'b101, 0, 32'd0, 32'd0, 3'b000, 1,
                  1, 0, 1, 0, 32'd2, 0, 4'd2);
    vecs[4]  = mk(0, 32'hDEAD_BEEF, 32'h1234_5678, 3'b001, 1, 32'h0000_00F0, 32'h0000_000F, 3'b011, 1,
                  0, 1, 1, 1, 32'h0000_00FF, 0, 4'd3);
    vecs[5]  = mk(1, 32'h10, 32'h20, 3'b010, 1, 32'h8000_0000, 32'd1, 3'b110, 1,
                  1, 0, 1, 0, 32'd0, 1, 4'd4);
    vecs[6]  = mk(1, 32'h10, 32'h20, 3'b010, 1, 32'h8000_0000, 32'd1, 3'b110, 1,
                  FIXED, !FIXED, 1, !FIXED, FIXED ? 32'd0 : 32'h4000_0000, FIXED, 4'd5);
    vecs[7]  = mk(1, 32'hFFFF_0000, 32'h0F0F_0F0F, 3'b100, 0, 32'd0, 32'd0, 3'b000, 1,
                  1, 0, 1, 0, 32'hF0F0_0F0F, 0, 4'd6);
    vecs[8]  = mk(1, 32'hFFFF_FFFE, 32'd1, 3'b111, 0, 32'd0, 32'd0, 3'b000, 1,
                  1, 0, 1, 0, 32'd1, 0, 4'd7);
    vecs[9]  = mk(1, 32'd5, 32'h8000_0000, 3'b111, 0, 32'd0, 32'd0, 3'b000, 1,
                  1, 0, 1, 0, 32'd0, 1, 4'd8);
    vecs[10] = mk(1, 32'd0, 32'd1, 3'b001, 0, 32'd0, 32'd0, 3'b000, 1,
                  1, 0, 1, 0, 32'hFFFF_FFFF, 0, 4'd9);
    vecs[11] = mk(1, 32'd3, 32'h1F, 3'b101, 0, 32'd0, 32'd0, 3'b000, 1,
                  1, 0, 1, 0, 32'h8000_0000, 0, 4'd10);
    vecs[12] = mk(0, 32'd0, 32'd0, 3'b000, 1, 32'hFFFF_FFFF, 32'd1, 3'b111, 1,
                  0, 1, 1, 1, 32'd1, 0, 4'd11);
    vecs[13] = mk(1, 32'd5, 32'd3, 3'b000, 1, 32'd9, 32'd9, 3'b001, 0,
                  0, 0, 1, 1, 32'd1, 0, 4'd11);
    vecs[14] = mk(1, 32'd5, 32'd3, 3'b000, 1, 32'd9, 32'd9, 3'b001, 0,
                  0, 0, 1, 1, 32'd1, 0, 4'd11);
    vecs[15] = mk(1, 32'd5, 32'd3, 3'b000, 1, 32'd9, 32'd9, 3'b001, 0,
                  0, 0, 1, 1, 32'd1, 0, 4'd11);
    vecs[16] = mk(1, 32'd5, 32'd3, 3'b000, 1, 32'd9, 32'd9, 3'b001, 1,
                  1, 0, 1, 0, 32'd8, 0, 4'd12);
    vecs[17] = mk(0, 32'd0, 32'd0, 3'b000, 0, 32'd0, 32'd0, 3'b000, 1,
                  0, 0, 0, 0, 32'd0, 0, 4'd13);

    // Reset: requests pending but nothing may be acknowledged
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_op = 3'b000;
    req1_valid = 1'b1; req1_a = 32'd2; req1_b = 32'd2; req1_op = 3'b000;
    rsp_ready = 1'b1;
    #2;
    checkOutput("reset req0_ready", {31'd0, req0_ready}, 32'd0);
    checkOutput("reset req1_ready", {31'd0, req1_ready}, 32'd0);
    checkOutput("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("reset rsp_id", {31'd0, rsp_id}, 32'd0);
    checkOutput("reset rsp_result", rsp_result, 32'd0);
    checkOutput("reset rsp_zero", {31'd0, rsp_zero}, 32'd0);
    checkOutput("reset op_count", {28'd0, op_count}, 32'd0);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst_n = 1'b1;

    // Table-driven section
    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d req0_ready", i), {31'd0, req0_ready}, {31'd0, vecs[i].e_r0});
      checkOutput($sformatf("v%0d req1_ready", i), {31'd0, req1_ready}, {31'd0, vecs[i].e_r1});
      @(posedge clk);
      #1;
      checkOutput($sformatf("v%0d rsp_valid", i), {31'd0, rsp_valid}, {31'd0, vecs[i].e_valid});
      if (vecs[i].e_valid) begin
        checkOutput($sformatf("v%0d rsp_id", i), {31'd0, rsp_id}, {31'd0, vecs[i].e_id});
        checkOutput($sformatf("v%0d rsp_result", i), rsp_result, vecs[i].e_result);
        checkOutput($sformatf("v%0d rsp_zero", i), {31'd0, rsp_zero}, {31'd0, vecs[i].e_zero});
      end
      checkOutput($sformatf("v%0d op_count", i), {28'd0, op_count}, {28'd0, vecs[i].e_count});
    end

    // Reset while a response is held: fill the slot and stall it
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 32'd9; req0_b = 32'd1; req0_op = 3'b000;
    req1_valid = 1'b0;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midrst filled valid", {31'd0, rsp_valid}, 32'd1);
    checkOutput("midrst filled result", rsp_result, 32'd10);
    @(negedge clk);
    req1_valid = 1'b1;
    rsp_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("midrst op_count", {28'd0, op_count}, 32'd0);
    checkOutput("midrst rsp_result", rsp_result, 32'd0);
    checkOutput("midrst req0_ready", {31'd0, req0_ready}, 32'd0);
    checkOutput("midrst req1_ready", {31'd0, req1_ready}, 32'd0);

    // Contention straight out of reset: both valid for four accepts
    @(negedge clk);
    req0_a = 32'd1; req0_b = 32'd2; req0_op = 3'b000;
    req1_a = 32'd10; req1_b = 32'd20; req1_op = 3'b000;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic exp_id;
      exp_id = FIXED ? 1'b0 : k[0];
      @(posedge clk);
      #1;
      checkOutput($sformatf("contend%0d rsp_valid", k), {31'd0, rsp_valid}, 32'd1);
      checkOutput($sformatf("contend%0d rsp_id", k), {31'd0, rsp_id}, {31'd0, exp_id});
      checkOutput($sformatf("contend%0d rsp_result", k), rsp_result, exp_id ? 32'd30 : 32'd3);
    end
    checkOutput("contend op_count", {28'd0, op_count}, 32'd3);

    // Counter wrap: 17 back-to-back operations, all consumed
    @(negedge clk);
    req1_valid = 1'b0;
    req0_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    req0_valid = 1'b1;
    for (int k = 0; k < 17; k++) begin
      @(posedge clk);
    end
    #1;
    checkOutput("wrap op_count at 16", {28'd0, op_count}, 32'd0);
    @(negedge clk);
    req0_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("wrap op_count at 17", {28'd0, op_count}, 32'd1);
    checkOutput("wrap rsp_valid", {31'd0, rsp_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
